// File: rtl/bf_pkeygen_seq.sv
// bf_pkeygen_seq: Blowfish P-array key schedule.
//   Buffers up to MAX_KEY_WORDS 32-bit key words. On start, rebuilds every P
//   entry from the init table XORed with the cyclically repeated key, one
//   entry per cycle. The key is applied in forward order (mode=1) or reversed
//   order (mode=0).
// Ports:
//   Clk, RstN                       clock, synchronous active-low reset
//   key_wr_en/key_wr_addr/key_wr_data  key buffer write (honoured in IDLE only)
//   key_len, mode, start            run launch; key_len and mode sampled with start
//   rd_addr -> rd_data              combinational P read, 0 when out of range
//   busy, done, ready, err          registered status
//   zeroize                         present only when BF_PKEYGEN_ZEROIZE_EN is defined
// Build option: define BF_PKEYGEN_ZEROIZE_EN to add the zeroize input.
module bf_pkeygen_seq #(
    parameter int unsigned NUM_P         = 20,
    parameter int unsigned MAX_KEY_WORDS = 14,
    parameter int unsigned KA_W          = $clog2(MAX_KEY_WORDS),
    parameter int unsigned KL_W          = $clog2(MAX_KEY_WORDS + 1),
    parameter int unsigned PA_W          = 5
) (
    input  logic            Clk,
    input  logic            RstN,
`ifdef BF_PKEYGEN_ZEROIZE_EN
    input  logic            zeroize,
`endif
    input  logic            key_wr_en,
    input  logic [KA_W-1:0] key_wr_addr,
    input  logic [31:0]     key_wr_data,
    input  logic [KL_W-1:0] key_len,
    input  logic            mode,
    input  logic            start,
    input  logic [PA_W-1:0] rd_addr,
    output logic [31:0]     rd_data,
    output logic            busy,
    output logic            done,
    output logic            ready,
    output logic            err
);

    localparam logic [31:0] P_INIT_TAB [0:19] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
        32'h9216D5D9, 32'h8979FB1B, 32'h578FDFE3, 32'h3AC372E6
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XOR  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          state;
    logic [31:0]     p       [NUM_P];
    logic [31:0]     key_buf [MAX_KEY_WORDS];
    logic [PA_W-1:0] idx;
    logic [KA_W-1:0] kidx;
    logic [KL_W-1:0] len_q;
    logic            mode_q;

    // Clear request: reset, or zeroize when that option is built in
    logic zclr;
`ifdef BF_PKEYGEN_ZEROIZE_EN
    assign zclr = zeroize;
`else
    assign zclr = 1'b0;
`endif

    logic            len_bad;
    logic            wr_ok;
    logic [PA_W-1:0] p_sel;
    logic            kidx_last;

    assign len_bad   = (key_len == '0) || (32'(key_len) > MAX_KEY_WORDS);
    assign wr_ok     = 32'(key_wr_addr) < MAX_KEY_WORDS;
    // Decrypt order fills the array from the top entry downward
    assign p_sel     = mode_q ? idx : (PA_W'(NUM_P - 1) - idx);
    assign kidx_last = (kidx == KA_W'(len_q - KL_W'(1)));

    // Schedule FSM, key buffer and P array
    always_ff @(posedge Clk) begin
        if (!RstN || zclr) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            ready  <= 1'b0;
            err    <= 1'b0;
            idx    <= '0;
            kidx   <= '0;
            len_q  <= '0;
            mode_q <= 1'b0;
            for (int i = 0; i < int'(NUM_P); i++) p[i] <= P_INIT_TAB[i];
            for (int j = 0; j < int'(MAX_KEY_WORDS); j++) key_buf[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_wr_en && wr_ok) begin
                        key_buf[key_wr_addr] <= key_wr_data;
                        ready                <= 1'b0;
                    end
                    if (start) begin
                        len_q  <= key_len;
                        mode_q <= mode;
                        ready  <= 1'b0;
                        if (len_bad) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            idx   <= '0;
                            kidx  <= '0;
                            state <= S_XOR;
                        end
                    end
                end
                S_XOR: begin
                    p[p_sel] <= P_INIT_TAB[p_sel] ^ key_buf[kidx];
                    kidx     <= kidx_last ? '0 : kidx + KA_W'(1);
                    idx      <= idx + PA_W'(1);
                    if (idx == PA_W'(NUM_P - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Indexed read port; out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < NUM_P) rd_data = p[rd_addr];
    end

endmodule

// File: tb/tb_bf_pkeygen_seq.sv
module tb_bf_pkeygen_seq;

    localparam int NP   = 20;
    localparam int MKW  = 14;
    localparam int KA_W = 4;
    localparam int KL_W = 4;
    localparam int PA_W = 5;

    logic            Clk = 1'b0;
    logic            RstN;
    logic            zeroize;
    logic            key_wr_en;
    logic [KA_W-1:0] key_wr_addr;
    logic [31:0]     key_wr_data;
    logic [KL_W-1:0] key_len;
    logic            mode;
    logic            start;
    logic [PA_W-1:0] rd_addr;
    logic [31:0]     rd_data;
    logic            busy, done, ready, err;

    bf_pkeygen_seq dut (
        .Clk(Clk), .RstN(RstN),
`ifdef BF_PKEYGEN_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
        .key_len(key_len), .mode(mode), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .ready(ready), .err(err)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] p_init [NP];
    logic [31:0] mk     [MKW];
    logic [31:0] mp     [NP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: entry i of the key stream uses key word i mod len
    function automatic void model_run(input int len, input bit md);
        for (int i = 0; i < NP; i++) begin
            if (md) mp[i] = p_init[i] ^ mk[i % len];
            else    mp[NP-1-i] = p_init[NP-1-i] ^ mk[i % len];
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < MKW; i++) mk[i] = '0;
        for (int i = 0; i < NP; i++) mp[i] = p_init[i];
    endfunction

    task automatic rd(input int a, output logic [31:0] v);
        rd_addr = PA_W'(a);
        tick();
        v = rd_data;
    endtask

    task automatic check_p(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            chk($sformatf("%s_p%0d", tag, i), v, (i < NP) ? mp[i] : 32'h0);
        end
    endtask

    task automatic wr_key(input int a, input logic [31:0] d);
        key_wr_en = 1'b1; key_wr_addr = KA_W'(a); key_wr_data = d;
        tick();
        key_wr_en = 1'b0;
        if (a < MKW) mk[a] = d;
    endtask

    // Launch a run; legal runs must pulse done 21 edges after the start edge
    task automatic run_sched(input string tag, input int len, input bit md);
        int  n;
        bit  legal;
        legal = (len >= 1) && (len <= MKW);
        key_len = KL_W'(len); mode = md; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'(legal));
        n = 0;
        while (!done && n < 60) begin tick(); n++; end
        chk({tag, "_done_seen"}, 32'(done), 32'h1);
        if (legal) begin
            chk({tag, "_latency"}, n, NP + 1);
            chk({tag, "_ready"}, 32'(ready), 32'h1);
            model_run(len, md);
        end else begin
            chk({tag, "_err"}, 32'(err), 32'h1);
            chk({tag, "_ready_low"}, 32'(ready), 32'h0);
        end
        tick();
        chk({tag, "_done_once"}, 32'(done), 32'h0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'h0);
    endtask

    task automatic apply_reset();
        RstN = 1'b0;
        tick(); tick();
        RstN = 1'b1;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int dcount, first, len;
        bit md;
        p_init = '{32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
                   32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
                   32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
                   32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
                   32'h9216D5D9, 32'h8979FB1B, 32'h578FDFE3, 32'h3AC372E6};
        RstN = 1'b0; zeroize = 1'b0; key_wr_en = 1'b0; key_wr_addr = '0;
        key_wr_data = '0; key_len = '0; mode = 1'b0; start = 1'b0; rd_addr = '0;
        apply_reset();

        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(done), 0);
        check_p("rst");

        // Zero key leaves the init table intact
        wr_key(0, 32'h0);
        run_sched("t1", 1, 1'b1);
        rd(0, v);  chk("t1_p0", v, 32'h243F6A88);
        rd(19, v); chk("t1_p19", v, 32'h3AC372E6);
        check_p("t1");

        wr_key(0, 32'hFFFFFFFF);
        chk("wr_clears_ready", 32'(ready), 0);
        run_sched("t2", 1, 1'b1);
        rd(0, v);  chk("t2_p0", v, 32'hDBC09577);
        rd(19, v); chk("t2_p19", v, 32'hC53C8D19);

        wr_key(0, 32'h1); wr_key(1, 32'h2);
        run_sched("t3e", 2, 1'b1);
        rd(0, v); chk("t3e_p0", v, 32'h243F6A89);
        rd(1, v); chk("t3e_p1", v, 32'h85A308D1);
        run_sched("t3d", 2, 1'b0);
        rd(19, v); chk("t3d_p19", v, 32'h3AC372E7);
        rd(18, v); chk("t3d_p18", v, 32'h578FDFE1);
        check_p("t3d");

        // Illegal lengths: P untouched, err held until a legal start
        run_sched("t4z", 0, 1'b1);
        check_p("t4z");
        chk("t4_err_held", 32'(err), 1);
        run_sched("t4o", 15, 1'b1);
        chk("t4o_err_held", 32'(err), 1);
        run_sched("t4ok", 2, 1'b1);
        chk("t4_err_cleared", 32'(err), 0);
        check_p("t4ok");

        // Mid-run start and key write are dropped
        key_len = KL_W'(2); mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; dcount = 0; first = 0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 5) begin
                start = 1'b1; key_wr_en = 1'b1; key_wr_addr = '0;
                key_wr_data = 32'hDEADBEEF; key_len = KL_W'(1); mode = 1'b0;
            end
            tick();
            start = 1'b0; key_wr_en = 1'b0;
            if (done) begin dcount++; if (first == 0) first = e; end
        end
        chk("t5_done_count", dcount, 1);
        chk("t5_done_edge", first, NP + 1);
        model_run(2, 1'b1);
        check_p("t5");
        run_sched("t5b", 2, 1'b1);
        check_p("t5b");

        // Randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < MKW; k++) wr_key(k, $urandom);
            len = $urandom_range(1, MKW);
            md  = 1'($urandom_range(0, 1));
            run_sched($sformatf("rnd%0d", r), len, md);
            chk($sformatf("rnd%0d_err", r), 32'(err), 0);
            check_p($sformatf("rnd%0d", r));
        end

        // Reset mid-run
        rd_addr = '0;
        key_len = KL_W'(3); mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e < 8; e++) tick();
        RstN = 1'b0;
        tick();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ready", 32'(ready), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_rd0", rd_data, 32'h243F6A88);
        RstN = 1'b1;
        model_clear();
        run_sched("t6b", MKW, 1'b1);
        check_p("t6b");

`ifdef BF_PKEYGEN_ZEROIZE_EN
        for (int k = 0; k < MKW; k++) wr_key(k, $urandom);
        rd_addr = '0;
        key_len = KL_W'(5); mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e < 8; e++) tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("z_busy", 32'(busy), 0);
        chk("z_ready", 32'(ready), 0);
        chk("z_done", 32'(done), 0);
        chk("z_rd0", rd_data, 32'h243F6A88);
        model_clear();
        run_sched("zb", 4, 1'b0);
        check_p("zb");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
